// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared types and defaults for the Booth multiplier arbiter.
package booth_arb_pkg;

   // Sequencer states: accept a job, start the multiplier, wait, respond.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam int ARB_NREQ_DEF    = 4;
   localparam int ARB_W_DEF       = 8;
   localparam int ARB_TIMEOUT_DEF = 64;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Searches upward from
// last_grant+1 (modulo NREQ) and returns a one-hot grant plus its index.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            found
);

   // First requester after the previous winner takes the grant.
   always_comb begin
      int  idx;
      logic take;
      grant     = {NREQ{1'b0}};
      grant_idx = {IW{1'b0}};
      found     = 1'b0;
      idx       = 0;
      take      = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx        = (int'(last_grant) + k) % NREQ;
         take       = !found && req[idx];
         grant[idx] = grant[idx] | take;
         grant_idx  = take ? IW'(idx) : grant_idx;
         found      = found | take;
      end
   end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: shares one signed Booth multiplier among NREQ clients.
// One job in flight at a time; round-robin acceptance; one-cycle response.
// Optional watchdog abort in WAIT: define BOOTH_ARB_WATCHDOG_EN.
module booth_mult_arbiter
   import booth_arb_pkg::*;
#(
   parameter int NREQ        = ARB_NREQ_DEF,
   parameter int W           = ARB_W_DEF,
   parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_A,
   input  logic [NREQ*W-1:0] req_B,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [2*W-1:0]    rsp_Mult,
   output logic              rsp_err,
   output logic              busy,
   output logic              mul_valid,
   output logic [W-1:0]      mul_A,
   output logic [W-1:0]      mul_B,
   input  logic [2*W-1:0]    mul_Mult,
   input  logic              mul_done
);

   localparam int IW = idx_width(NREQ);
   localparam logic [NREQ-1:0] REQ_ONE = {{(NREQ-1){1'b0}}, 1'b1};

   arb_state_t      state_r, state_s;
   logic [IW-1:0]   last_grant_r, gnt_idx_r, pick_idx_s;
   logic [NREQ-1:0] pick_onehot_s, rsp_valid_r;
   logic            pick_any_s;
   logic [W-1:0]    a_r, b_r;
   logic [2*W-1:0]  prod_r;
   logic            done_q_r, done_edge_s, wd_hit_s;
   logic            mul_valid_r, busy_r;

   rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req        (req_valid),
      .last_grant (last_grant_r),
      .grant      (pick_onehot_s),
      .grant_idx  (pick_idx_s),
      .found      (pick_any_s)
   );

   // Only a fresh rising edge counts; a level left high from before is stale.
   assign done_edge_s = mul_done & ~done_q_r;

   // The grant is offered only in IDLE and withheld while reset is applied,
   // so a handshake can never complete into a job that reset discards.
   assign req_ready = ((state_r == IDLE) && !rst) ? pick_onehot_s : {NREQ{1'b0}};

   assign rsp_valid = rsp_valid_r;
   assign rsp_Mult  = prod_r;
   assign busy      = busy_r;
   assign mul_valid = mul_valid_r;
   assign mul_A     = a_r;
   assign mul_B     = b_r;

`ifdef BOOTH_ARB_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   logic [WDW-1:0] wd_cnt_r;
   logic           rsp_err_r;

   // Count cycles spent in WAIT (zero on entry) and flag aborted responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_r  <= {WDW{1'b0}};
         rsp_err_r <= 1'b0;
      end else begin
         wd_cnt_r  <= (state_r == WAIT) ? (wd_cnt_r + WDW'(1)) : {WDW{1'b0}};
         rsp_err_r <= (state_r == WAIT) && wd_hit_s && !done_edge_s;
      end
   end

   assign wd_hit_s = (state_r == WAIT) && (wd_cnt_r == WDW'(TIMEOUT_CYC - 1));
   assign rsp_err  = rsp_err_r;
`else
   // No watchdog in this build: the limit parameter can never make this true.
   assign wd_hit_s = (TIMEOUT_CYC < 0);
   assign rsp_err  = 1'b0;
`endif

   // Next-state selection for the accept / issue / wait / respond sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (pick_any_s) state_s = ISSUE;
            else            state_s = IDLE;
         end
         ISSUE: state_s = WAIT;
         WAIT: begin
            if (done_edge_s || wd_hit_s) state_s = RESP;
            else                         state_s = WAIT;
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register, operand/product capture and registered output strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         last_grant_r <= IW'(NREQ - 1);
         gnt_idx_r    <= {IW{1'b0}};
         a_r          <= {W{1'b0}};
         b_r          <= {W{1'b0}};
         prod_r       <= {(2*W){1'b0}};
         done_q_r     <= 1'b0;
         rsp_valid_r  <= {NREQ{1'b0}};
         mul_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         done_q_r    <= mul_done;
         mul_valid_r <= (state_s == ISSUE);
         busy_r      <= (state_s != IDLE);
         rsp_valid_r <= (state_s == RESP) ? (REQ_ONE << gnt_idx_r) : {NREQ{1'b0}};
         if ((state_r == IDLE) && pick_any_s) begin
            a_r       <= req_A[int'(pick_idx_s)*W +: W];
            b_r       <= req_B[int'(pick_idx_s)*W +: W];
            gnt_idx_r <= pick_idx_s;
         end
         // A done edge on the limit cycle wins over the watchdog.
         if ((state_r == WAIT) && done_edge_s) begin
            prod_r <= mul_Mult;
         end else if ((state_r == WAIT) && wd_hit_s) begin
            prod_r <= {(2*W){1'b0}};
         end
         if (state_r == RESP) begin
            last_grant_r <= gnt_idx_r;
         end
      end
   end

endmodule
